vr_fifo: RTL and testbench

Parametrised valid/ready buffer: next generation of the single-stage valid/ready slice, generalised to configurable data width and depth. It adds occupancy and almost-full reporting, and an optional zero-latency fall-through path. It sits between any producer and consumer on a valid/ready link, absorbing backpressure bursts of up to DEPTH beats without dropping or duplicating data.

---
 rtl/vr_fifo_if.sv | 37 +++
 rtl/vr_fifo.sv | 91 +++++++++
 tb/tb_vr_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vr_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : vr_fifo_if
//  Description : Valid/ready link bundle for vr_fifo. Carries the upstream
//                beat (data_i/valid_i/ready_o), the downstream beat
//                (data_o/valid_o/ready_i) and the occupancy status
//                (count_o/afull_o).
//                  slave  : the FIFO side (drives ready_o, data_o, valid_o,
//                           count_o, afull_o)
//                  master : the environment side (drives data_i, valid_i,
//                           ready_i)
//  Revision    : 1.0  initial release
// ============================================================================
interface vr_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]      data_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [DATA_W-1:0]      data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [$clog2(DEPTH):0] count_o;
  logic                   afull_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, count_o, afull_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, count_o, afull_o
  );
endinterface
`default_nettype wire

// File: rtl/vr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vr_fifo
//  Description : Parametrised valid/ready FIFO buffer with occupancy and
//                almost-full reporting. Absorbs up to DEPTH beats of
//                downstream backpressure, strictly in order.
//                Optional macro VR_FIFO_BYPASS_EN enables a zero-latency
//                fall-through path while the buffer is empty.
//  Ports       : clk      - single clock, rising edge
//                rst_n    - synchronous active-low reset
//                bus      - vr_fifo_if.slave: data_i/valid_i/ready_o
//                           upstream, data_o/valid_o/ready_i downstream,
//                           count_o occupancy (0..DEPTH), afull_o
//                           (count_o >= AFULL_TH)
//  Revision    : 1.0  initial release
// ============================================================================
module vr_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  vr_fifo_if.slave    bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_afull_th = c_cnt_w'(AFULL_TH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);

  // Acceptance depends only on stored occupancy, never on ready_i, so no
  // combinational ready path runs through the block.
  assign bus.ready_o = rst_n & ~w_full;

`ifdef VR_FIFO_BYPASS_EN
  // Empty buffer: the upstream beat is presented directly. If the consumer
  // takes it in the same cycle it is never written into storage.
  assign bus.valid_o = rst_n & (~w_empty | bus.valid_i);
  assign bus.data_o  = ~rst_n  ? '0 :
                       w_empty ? bus.data_i : r_mem[r_rd_ptr];
  assign w_push      = bus.valid_i & bus.ready_o & ~(w_empty & bus.ready_i);
`else
  assign bus.valid_o = rst_n & ~w_empty;
  assign bus.data_o  = bus.valid_o ? r_mem[r_rd_ptr] : '0;
  assign w_push      = bus.valid_i & bus.ready_o;
`endif

  // Only stored beats advance the read pointer; a bypassed beat never does.
  assign w_pop = bus.valid_o & bus.ready_i & ~w_empty;

  assign bus.count_o = rst_n ? r_count : '0;
  assign bus.afull_o = rst_n & (r_count >= c_afull_th);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; w_push is already gated by rst_n
  // through ready_o.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_vr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vr_fifo
//  Description : Self-checking bench for vr_fifo (DATA_W=8, DEPTH=4,
//                AFULL_TH=3). Table of per-cycle vectors plus hand-written
//                wrap and fall-through sequences. Expectations follow
//                VR_FIFO_BYPASS_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vr_fifo;

`ifdef VR_FIFO_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic clk = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;

  vr_fifo_if #(.DATA_W(8), .DEPTH(4)) bus ();

  vr_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       rdy_in;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_count;
    logic       e_afull;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic ri, input logic er, input logic ev,
                              input logic [7:0] ed, input logic [2:0] ec,
                              input logic ea);
    vec_t t;
    t.rst_n = r;  t.valid = v;  t.data = d;  t.rdy_in = ri;
    t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_afull = ea;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic ri);
    rst_n       = r;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = ri;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int sent;
  int recv;

  initial begin
    //            rst v  data   ri  rdy val  data        cnt af
    // reset held three edges with a pending 55
    vecs.push_back(mk(0, 1, 8'h55, 0,  0, 0, 8'h00,       0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0,  0, 0, 8'h00,       0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0,  0, 0, 8'h00,       0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));
    // streaming with ready_i high
    vecs.push_back(mk(1, 1, 8'h3C, 1,  1, c_byp, c_byp ? 8'h3C : 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'h48, 1,  1, 1, c_byp ? 8'h48 : 8'h3C, c_byp ? 3'd0 : 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, !c_byp, c_byp ? 8'h00 : 8'h48, c_byp ? 3'd0 : 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));
    // backpressure fill, 5th beat held upstream
    vecs.push_back(mk(1, 1, 8'h24, 0,  1, c_byp, c_byp ? 8'h24 : 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'h25, 0,  1, 1, 8'h24,       1, 0));
    vecs.push_back(mk(1, 1, 8'h26, 0,  1, 1, 8'h24,       2, 0));
    vecs.push_back(mk(1, 1, 8'h27, 0,  1, 1, 8'h24,       3, 1));
    vecs.push_back(mk(1, 1, 8'h28, 0,  0, 1, 8'h24,       4, 1));
    // full with pop and valid_i: pop happens, push refused
    vecs.push_back(mk(1, 1, 8'h28, 1,  0, 1, 8'h24,       4, 1));
    vecs.push_back(mk(1, 1, 8'h28, 1,  1, 1, 8'h25,       3, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 8'h26,       3, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 8'h27,       2, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 1, 8'h28,       1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));
    // reset mid-operation discards stored beats
    vecs.push_back(mk(1, 1, 8'h77, 0,  1, c_byp, c_byp ? 8'h77 : 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'h78, 0,  1, 1, 8'h77,       1, 0));
    vecs.push_back(mk(0, 1, 8'h79, 1,  0, 0, 8'h00,       0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1,  1, 0, 8'h00,       0, 0));

    drive(0, 0, 8'h00, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].valid, vecs[i].data, vecs[i].rdy_in);
      @(negedge clk);
      chk($sformatf("v%0d ready_o", i), {7'd0, bus.ready_o}, {7'd0, vecs[i].e_ready});
      chk($sformatf("v%0d valid_o", i), {7'd0, bus.valid_o}, {7'd0, vecs[i].e_valid});
      chk($sformatf("v%0d data_o",  i), bus.data_o,          vecs[i].e_data);
      chk($sformatf("v%0d count_o", i), {5'd0, bus.count_o}, {5'd0, vecs[i].e_count});
      chk($sformatf("v%0d afull_o", i), {7'd0, bus.afull_o}, {7'd0, vecs[i].e_afull});
      next_cycle();
    end

    // wrap: 11 beats with random consumer stalls, order must be preserved
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 11; cyc++) begin
      drive(1, sent < 11, 8'(sent), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (bus.valid_o && bus.ready_i) begin
        chk($sformatf("wrap beat %0d", recv), bus.data_o, 8'(recv));
        recv++;
      end
      if (bus.valid_i && bus.ready_o) sent++;
      next_cycle();
    end
    chk("wrap beats received", 8'(recv), 8'd11);
    drive(1, 0, 8'h00, 1);
    @(negedge clk);
    chk("wrap count_o", {5'd0, bus.count_o}, 8'd0);
    chk("wrap valid_o", {7'd0, bus.valid_o}, 8'd0);
    next_cycle();

    // fall-through: same-cycle with the bypass, one cycle later without
    drive(1, 1, 8'h3C, 1);
    @(negedge clk);
    chk("ft valid_o same cycle", {7'd0, bus.valid_o}, {7'd0, c_byp});
    chk("ft data_o same cycle",  bus.data_o, c_byp ? 8'h3C : 8'h00);
    next_cycle();
    drive(1, 0, 8'h00, 1);
    @(negedge clk);
    chk("ft count_o next", {5'd0, bus.count_o}, c_byp ? 8'd0 : 8'd1);
    chk("ft valid_o next", {7'd0, bus.valid_o}, {7'd0, !c_byp});
    chk("ft data_o next",  bus.data_o, c_byp ? 8'h00 : 8'h3C);
    next_cycle();
    @(negedge clk);
    chk("ft drained count_o", {5'd0, bus.count_o}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
